// File: rtl/onchip_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter_if
// Avalon-MM command/response link between one requesting master and the
// arbiter.
//   address       master -> slave  word address
//   byteenable    master -> slave  active byte lanes
//   read          master -> slave  read request
//   write         master -> slave  write request (wins if read is also high)
//   writedata     master -> slave  write data
//   waitrequest   slave -> master  command not accepted this cycle
//   readdata      slave -> master  read data
//   readdatavalid slave -> master  readdata is valid for this master
// -----------------------------------------------------------------------------
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares one single-port on-chip RAM (1-cycle read latency) between two
// Avalon-MM masters: port 0 (CPU data master) and port 1 (graphics engine).
// One command is forwarded combinationally per cycle; ties go to the port
// that did not win last. Issued reads are tagged so the returning data is
// flagged valid only on the requesting port.
//   clk, reset       system clock, synchronous active-high reset
//   m0, m1           slave side of each master's Avalon-MM link
//   mem_*            command bus to the RAM, mem_readdata back from it
//   conflict_cnt     saturating count of cycles where both ports requested
// -----------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [CNT_W-1:0]    conflict_cnt
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e            r_last_winner;
  logic             r_rd_pend;
  port_e            r_rd_port;
  logic [CNT_W-1:0] r_conflict_cnt;

  logic  w_req0;
  logic  w_req1;
  logic  w_gnt0;
  logic  w_gnt1;
  logic  w_issue;
  logic  w_win_write;
  logic  w_rd_issue;
  port_e w_winner;

  assign w_req0 = m0.read | m0.write;
  assign w_req1 = m1.read | m1.write;

  // Grant is a pure function of the current requests and r_last_winner.
  // Gating with reset keeps the RAM idle and both masters stalled in reset.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (w_req0 && w_req1) begin
        w_gnt0 = (r_last_winner == PORT1);
        w_gnt1 = (r_last_winner == PORT0);
      end else begin
        w_gnt0 = w_req0;
        w_gnt1 = w_req1;
      end
    end
  end

  assign w_issue  = w_gnt0 | w_gnt1;
  assign w_winner = w_gnt1 ? PORT1 : PORT0;

  // A losing master sees waitrequest and must hold its command; nothing is
  // buffered here. Idle masters never see waitrequest outside reset.
  assign m0.waitrequest = reset | (w_req0 & ~w_gnt0);
  assign m1.waitrequest = reset | (w_req1 & ~w_gnt1);

  // Address/byteenable/writedata follow port 0 when idle; chipselect is low
  // then, so the RAM ignores them.
  assign w_win_write    = (w_winner == PORT1) ? m1.write : m0.write;
  assign mem_chipselect = w_issue;
  assign mem_write      = w_issue & w_win_write;
  assign mem_address    = (w_winner == PORT1) ? m1.address    : m0.address;
  assign mem_byteenable = (w_winner == PORT1) ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = (w_winner == PORT1) ? m1.writedata  : m0.writedata;

  // Read+write together is a write, so only a pure read creates a return.
  assign w_rd_issue = w_issue & ~w_win_write;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_winner  <= PORT1;
      r_rd_pend      <= 1'b0;
      r_rd_port      <= PORT0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_issue) begin
        r_last_winner <= w_winner;
      end
      r_rd_pend <= w_rd_issue;
      r_rd_port <= w_winner;
      if (w_req0 && w_req1 && (r_conflict_cnt != {CNT_W{1'b1}})) begin
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
    end
  end

  // Read data is broadcast; only the valid flag is steered. Gating with
  // reset drops a read return that coincides with the first reset cycle.
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = r_rd_pend & ~reset & (r_rd_port == PORT0);
  assign m1.readdatavalid = r_rd_pend & ~reset & (r_rd_port == PORT1);

  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_onchip_mem_arbiter
// Bench for onchip_mem_arbiter. One command pair is applied per cycle; a
// reference model predicts grants, waitrequests and the conflict count, keeps
// a shadow copy of RAM contents, and pushes each predicted read return onto a
// scoreboard queue that is popped when the return cycle arrives. A second
// instance with CNT_W = 4 checks counter saturation.
// -----------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } cmd_t;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W-1:0]   mem_readdata;
  logic [CNT_W-1:0]    conflict_cnt;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .m0            (m0_if),
    .m1            (m1_if),
    .mem_address   (mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .conflict_cnt  (conflict_cnt)
  );

  // 256x32 RAM with byte enables and registered read data.
  logic [31:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  initial mem_readdata = '0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // ---------------- saturation DUT (CNT_W = 4) ----------------
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s0_if ();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s1_if ();

  logic                reset_s;
  logic [ADDR_W-1:0]   s_mem_address;
  logic [DATA_W/8-1:0] s_mem_byteenable;
  logic                s_mem_chipselect;
  logic                s_mem_write;
  logic [DATA_W-1:0]   s_mem_writedata;
  logic [DATA_W-1:0]   s_mem_readdata = '0;
  logic [3:0]          s_conflict_cnt;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) dut_sat (
    .clk           (clk),
    .reset         (reset_s),
    .m0            (s0_if),
    .m1            (s1_if),
    .mem_address   (s_mem_address),
    .mem_byteenable(s_mem_byteenable),
    .mem_chipselect(s_mem_chipselect),
    .mem_write     (s_mem_write),
    .mem_writedata (s_mem_writedata),
    .mem_readdata  (s_mem_readdata),
    .conflict_cnt  (s_conflict_cnt)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] shadow [256];
  exp_t        exp_q [$];
  logic        m_last = 1'b1;
  int          m_cnt  = 0;
  logic        st0 = 1'b0, st1 = 1'b0;
  int          n_v0 = 0, n_v1 = 0;
  logic [31:0] last_rd0 = '0;

  initial for (int i = 0; i < 256; i++) shadow[i] = '0;

  function automatic cmd_t c_idle();
    return '0;
  endfunction

  function automatic cmd_t c_rd(input logic [7:0] a);
    cmd_t c = '0;
    c.rd = 1'b1; c.addr = a; c.be = 4'hF;
    return c;
  endfunction

  function automatic cmd_t c_wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    cmd_t c = '0;
    c.wr = 1'b1; c.addr = a; c.be = be; c.wd = d;
    return c;
  endfunction

  function automatic cmd_t c_rnd();
    cmd_t c = '0;
    int   k = $urandom_range(0, 3);
    c.rd   = (k == 1) || (k == 3);
    c.wr   = (k == 2) || (k == 3);
    c.addr = 8'h40 + 8'($urandom_range(0, 7));
    c.be   = 4'($urandom_range(1, 15));
    c.wd   = $urandom;
    return c;
  endfunction

  // One clock cycle: drive both commands, check the returning read from the
  // previous cycle, check this cycle's arbitration, then advance the model.
  task automatic step(input logic rst_in, input cmd_t c0, input cmd_t c1);
    logic q0, q1, g0, g1;
    cmd_t w;
    exp_t e;
    @(negedge clk);
    reset             = rst_in;
    m0_if.read        = c0.rd;
    m0_if.write       = c0.wr;
    m0_if.address     = c0.addr;
    m0_if.byteenable  = c0.be;
    m0_if.writedata   = c0.wd;
    m1_if.read        = c1.rd;
    m1_if.write       = c1.wr;
    m1_if.address     = c1.addr;
    m1_if.byteenable  = c1.be;
    m1_if.writedata   = c1.wd;
    #1;

    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (rst_in) begin
        chk("rdv0_in_reset", m0_if.readdatavalid, 1'b0);
        chk("rdv1_in_reset", m1_if.readdatavalid, 1'b0);
      end else begin
        chk("rdv0", m0_if.readdatavalid, e.port == 1'b0);
        chk("rdv1", m1_if.readdatavalid, e.port == 1'b1);
        chk("rdata_m0", m0_if.readdata, e.data);
        chk("rdata_m1", m1_if.readdata, e.data);
      end
    end else begin
      chk("rdv0_idle", m0_if.readdatavalid, 1'b0);
      chk("rdv1_idle", m1_if.readdatavalid, 1'b0);
    end
    if (m0_if.readdatavalid) begin
      n_v0++;
      last_rd0 = m0_if.readdata;
    end
    if (m1_if.readdatavalid) n_v1++;

    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));

    q0 = c0.rd | c0.wr;
    q1 = c1.rd | c1.wr;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst_in) begin
      if (q0 && q1) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = q0;
        g1 = q1;
      end
    end
    chk("m0_waitrequest", m0_if.waitrequest, rst_in | (q0 & !g0));
    chk("m1_waitrequest", m1_if.waitrequest, rst_in | (q1 & !g1));
    chk("mem_chipselect", mem_chipselect, g0 | g1);

    if (g0 || g1) begin
      w = g1 ? c1 : c0;
      chk("mem_address", 32'(mem_address), 32'(w.addr));
      chk("mem_write", mem_write, w.wr);
      if (w.wr) begin
        chk("mem_byteenable", 32'(mem_byteenable), 32'(w.be));
        chk("mem_writedata", mem_writedata, w.wd);
        for (int b = 0; b < 4; b++)
          if (w.be[b]) shadow[w.addr][8*b +: 8] = w.wd[8*b +: 8];
      end else begin
        exp_q.push_back('{port: g1, data: shadow[w.addr]});
      end
    end

    if (rst_in) begin
      m_last = 1'b1;
      m_cnt  = 0;
    end else begin
      if (g0 || g1) m_last = g1;
      if (q0 && q1 && m_cnt != 32'hFFFF) m_cnt++;
    end
    st0 = q0 & !g0;
    st1 = q1 & !g1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int   v0b, v1b;
    cmd_t r0, r1;

    reset = 1'b1;
    {m0_if.read, m0_if.write, m0_if.address, m0_if.byteenable, m0_if.writedata} = '0;
    {m1_if.read, m1_if.write, m1_if.address, m1_if.byteenable, m1_if.writedata} = '0;
    reset_s = 1'b1;
    {s0_if.read, s0_if.write, s0_if.address, s0_if.byteenable, s0_if.writedata} = '0;
    {s1_if.read, s1_if.write, s1_if.address, s1_if.byteenable, s1_if.writedata} = '0;

    // Reset, with requests present in the second cycle: both stalled.
    step(1'b1, c_idle(), c_idle());
    step(1'b1, c_rd(8'h10), c_rd(8'h20));

    // Single-port write then read.
    step(1'b0, c_wr(8'h10, 4'hF, 32'hDEADBEEF), c_idle());
    step(1'b0, c_rd(8'h10), c_idle());
    v1b = n_v1;
    step(1'b0, c_idle(), c_idle());
    chk("wr_rd_data", last_rd0, 32'hDEADBEEF);
    chk("wr_rd_m1_quiet", 32'(n_v1 - v1b), 32'd0);

    // Preload, then clear the counter and stream from both ports.
    step(1'b0, c_wr(8'h01, 4'hF, 32'h11111111), c_idle());
    step(1'b0, c_idle(), c_wr(8'h02, 4'hF, 32'h22222222));
    step(1'b1, c_idle(), c_idle());
    v0b = n_v0;
    v1b = n_v1;
    repeat (6) step(1'b0, c_rd(8'h01), c_rd(8'h02));
    step(1'b0, c_idle(), c_idle());
    chk("stream_conflicts", 32'(conflict_cnt), 32'd6);
    chk("stream_rdv0_count", 32'(n_v0 - v0b), 32'd3);
    chk("stream_rdv1_count", 32'(n_v1 - v1b), 32'd3);

    // Partial byte write by port 1, read back by port 0.
    step(1'b0, c_wr(8'h20, 4'hF, 32'h12345678), c_idle());
    step(1'b0, c_idle(), c_wr(8'h20, 4'h2, 32'h0000AB00));
    step(1'b0, c_rd(8'h20), c_idle());
    step(1'b0, c_idle(), c_idle());
    chk("byte_merge", last_rd0, 32'h1234AB78);

    // Reset right after a read is accepted: return is dropped, first tie
    // afterwards goes to port 0, stalled port 1 holds its read.
    step(1'b0, c_rd(8'h10), c_idle());
    step(1'b1, c_rd(8'h01), c_rd(8'h02));
    step(1'b0, c_rd(8'h01), c_rd(8'h02));
    step(1'b0, c_idle(), c_rd(8'h02));
    step(1'b0, c_idle(), c_idle());

    // Same-address read (port 0) and write (port 1) in the same cycle.
    step(1'b0, c_idle(), c_wr(8'h30, 4'hF, 32'hAAAA0000));
    step(1'b0, c_rd(8'h30), c_wr(8'h30, 4'hF, 32'h55555555));
    step(1'b0, c_idle(), c_wr(8'h30, 4'hF, 32'h55555555));
    chk("same_addr_old", last_rd0, 32'hAAAA0000);
    step(1'b0, c_rd(8'h30), c_idle());
    step(1'b0, c_idle(), c_idle());
    chk("same_addr_new", last_rd0, 32'h55555555);

    // Random traffic; a stalled master re-presents its command.
    r0 = c_idle();
    r1 = c_idle();
    for (int i = 0; i < 60; i++) begin
      if (!st0) r0 = c_rnd();
      if (!st1) r1 = c_rnd();
      step(1'b0, r0, r1);
    end
    step(1'b0, c_idle(), c_idle());
    step(1'b0, c_idle(), c_idle());
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Saturation on the 4-bit instance: 2^4 + 3 conflict cycles.
    @(negedge clk);
    reset_s = 1'b0;
    s0_if.read = 1'b1;
    s1_if.read = 1'b1;
    for (int k = 0; k < 19; k++) begin
      #1;
      chk("sat_cnt", 32'(s_conflict_cnt), (k > 15) ? 32'd15 : 32'(k));
      @(negedge clk);
    end
    #1;
    chk("sat_final", 32'(s_conflict_cnt), 32'hF);
    s0_if.read = 1'b0;
    s1_if.read = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
